// File: rtl/irq_pkg.sv
// Shared encodings for the interrupt controller: FSM states, config register
// selects and STATUS field positions.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } irq_state_e;

  localparam logic [1:0] CFG_ENABLE  = 2'd0;
  localparam logic [1:0] CFG_PENDING = 2'd1;
  localparam logic [1:0] CFG_STATUS  = 2'd2;

  localparam int unsigned STATUS_BUSY_BIT  = 31;
  localparam int unsigned STATUS_STATE_LSB = 8;

endpackage

// File: rtl/irq_controller_if.sv
// Config bus plus core-side irq/irq_addr/irq_active/irq_ack handshake.
interface irq_controller_if;

  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wd;
  logic [31:0] cfg_rd;
  logic        irq;
  logic [31:0] irq_addr;
  logic        irq_active;
  logic        irq_ack;

  modport slave (
    input  cfg_we, cfg_sel, cfg_wd, irq_active, irq_ack,
    output cfg_rd, irq, irq_addr
  );

  modport master (
    output cfg_we, cfg_sel, cfg_wd, irq_active, irq_ack,
    input  cfg_rd, irq, irq_addr
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag; purely combinational.
module irq_prio_enc #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    i_req,
  output logic [ID_W-1:0] o_id,
  output logic            o_valid
);

  always_comb begin
    o_id    = '0;
    o_valid = 1'b0;
    // Walk downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_id    = ID_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Multi-channel interrupt controller: edge/level pending latches, enable mask,
// fixed-priority arbitration and a REQ/ACTIVE handshake with the core.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ      = 4,
  parameter logic [31:0] EDGE_MASK  = 32'h0000_000F,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0040,
  localparam int unsigned ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_IRQ-1:0]   i_irq_src,
  irq_controller_if.slave    io_bus,
  output logic [ID_W-1:0]    o_active_id,
  output logic               o_busy
);

  localparam logic [N_IRQ-1:0] EDGE_BITS = EDGE_MASK[N_IRQ-1:0];

  logic [N_IRQ-1:0] r_src_q, r_pending, r_enable;
  logic [N_IRQ-1:0] w_pending_d, w_set, w_w1c, w_id_hit, w_req;
  irq_state_e       r_state, w_state_d;
  logic [ID_W-1:0]  r_active_id, w_active_id_d, w_win;
  logic [31:0]      r_irq_addr, w_irq_addr_d, w_rd;
  logic             r_irq, w_irq_d, w_win_valid, w_entry, w_abort;

  irq_prio_enc #(
    .N    (N_IRQ),
    .ID_W (ID_W)
  ) u_prio_enc (
    .i_req   (w_req),
    .o_id    (w_win),
    .o_valid (w_win_valid)
  );

  assign w_req = r_pending & r_enable;

  always_comb begin
    w_set   = i_irq_src & ~r_src_q;
    w_w1c   = (io_bus.cfg_we && io_bus.cfg_sel == CFG_PENDING) ? io_bus.cfg_wd[N_IRQ-1:0] : '0;
    w_entry = (r_state == ST_REQ) && io_bus.irq_active;
    for (int i = 0; i < N_IRQ; i++) begin
      w_id_hit[i] = (r_active_id == ID_W'(i));
      // Edge channels: a fresh set beats any same-cycle clear.
      if (EDGE_BITS[i]) begin
        w_pending_d[i] = w_set[i] |
                         (r_pending[i] & ~(w_w1c[i] | (w_entry & w_id_hit[i])));
      end else begin
        w_pending_d[i] = i_irq_src[i];
      end
    end
    w_abort = (r_state == ST_REQ) && (|(w_id_hit & EDGE_BITS & w_w1c & ~w_set));
  end

  always_comb begin
    w_state_d     = r_state;
    w_active_id_d = r_active_id;
    w_irq_addr_d  = r_irq_addr;
    w_irq_d       = r_irq;
    unique case (r_state)
      ST_IDLE: begin
        if (w_win_valid) begin
          w_state_d     = ST_REQ;
          w_active_id_d = w_win;
          w_irq_addr_d  = VEC_BASE + VEC_STRIDE * 32'(w_win);
          w_irq_d       = 1'b1;
        end
      end
      ST_REQ: begin
        if (io_bus.irq_active) begin
          w_state_d = ST_ACTIVE;
          w_irq_d   = 1'b0;
        end else if (w_abort) begin
          w_state_d = ST_IDLE;
          w_irq_d   = 1'b0;
        end
      end
      ST_ACTIVE: begin
        w_irq_d = 1'b0;
        if (io_bus.irq_ack) w_state_d = ST_IDLE;
      end
      default: begin
        w_state_d = ST_IDLE;
        w_irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_src_q     <= '0;
      r_pending   <= '0;
      r_enable    <= '0;
      r_state     <= ST_IDLE;
      r_active_id <= '0;
      r_irq_addr  <= VEC_BASE;
      r_irq       <= 1'b0;
    end else begin
      r_src_q     <= i_irq_src;
      r_pending   <= w_pending_d;
      r_state     <= w_state_d;
      r_active_id <= w_active_id_d;
      r_irq_addr  <= w_irq_addr_d;
      r_irq       <= w_irq_d;
      if (io_bus.cfg_we && io_bus.cfg_sel == CFG_ENABLE) begin
        r_enable <= io_bus.cfg_wd[N_IRQ-1:0];
      end
    end
  end

  always_comb begin
    w_rd = '0;
    unique case (io_bus.cfg_sel)
      CFG_ENABLE:  w_rd[N_IRQ-1:0] = r_enable;
      CFG_PENDING: w_rd[N_IRQ-1:0] = r_pending;
      CFG_STATUS: begin
        w_rd[STATUS_BUSY_BIT]                        = (r_state != ST_IDLE);
        w_rd[STATUS_STATE_LSB+1:STATUS_STATE_LSB]    = r_state;
        w_rd[ID_W-1:0]                               = r_active_id;
      end
      default:     w_rd = '0;
    endcase
  end

  assign io_bus.cfg_rd   = w_rd;
  assign io_bus.irq      = r_irq;
  assign io_bus.irq_addr = r_irq_addr;
  assign o_active_id     = r_active_id;
  assign o_busy          = (r_state != ST_IDLE);

endmodule
